pipe_skid_latch: RTL and testbench
==================================

Name: pipe_skid_latch

Overview:
- Parametrised successor to the fixed 32-bit memory/writeback pipeline latch.
- Registers one pipeline-stage bundle per transfer: ALU result, memory data, instruction and overflow flag.
- Adds a valid/ready handshake and a 2-entry skid buffer, so the downstream stage can stall without a combinational ready path back upstream.
- Adds flush-to-NOP, plus a saturating stall counter for performance debug.
- Sits between any two processor stages; the first instance replaces the M/W latch.

Parameters:
- DATA_W, 32, width of o and d payload fields.
- INS_W, 32, width of the instruction field.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-low reset; state clears on a clk edge while reset==0.
- in_valid  in  1  upstream bundle valid.
- in_ready  out  1  latch can accept a bundle; registered.
- o_in  in  DATA_W  ALU/address result.
- d_in  in  DATA_W  memory/operand data.
- ins_in  in  INS_W  instruction word.
- ovf_in  in  1  overflow flag.
- flush  in  1  discard all held bundles.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream accepts.
- o_out  out  DATA_W  held o.
- d_out  out  DATA_W  held d.
- ins_out  out  INS_W  held instruction; all-zero (NOP) when not valid.
- ovf_out  out  1  held overflow flag.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0; saturates.

Behaviour:
- Storage: main entry (drives outputs) and skid entry, each holding {valid, o, d, ins, ovf}.
- Accept event: in_valid & in_ready. Emit event: out_valid & out_ready.
- Entry transitions per clk edge:
  - Empty + accept → main.
  - Main only + accept + emit → main replaced by the new bundle.
  - Main only + accept, no emit → new bundle into skid; in_ready goes 0 next cycle.
  - Main only + emit, no accept → empty.
  - Main + skid + emit → skid moves to main, skid cleared, in_ready goes 1 next cycle.
- Latency: 1 cycle from accept to out_valid when empty.
- Throughput: 1 bundle/cycle when out_ready is held high.
- Ordering: strictly FIFO. No loss or duplication.
- in_ready = !skid.valid, registered. in_valid is ignored while in_ready=0.
- Flush (synchronous, priority over accept and emit): both entries invalid next cycle. Bundle presented the same cycle is dropped. in_ready=1 next cycle. Fields zeroed. stall_cnt is not cleared.
- Invalid entries drive o_out=d_out=0, ins_out=0, ovf_out=0. Outputs never show stale data.
- stall_cnt increments each cycle with out_valid & !out_ready. Holds at 2^CNT_W−1. Cleared only by reset.
- Reset (reset==0 at edge), including mid-transfer:
  - All entries invalid and payload zeroed.
  - out_valid=0, in_ready=1, stall_cnt=0.
  - Handshake inputs ignored during the reset cycle.
- Payload widths pass through unchanged. No arithmetic on data.

Test Plan:
- Streaming: reset, out_ready=1, accept o=1..8 (d=o+100, ins=o) on consecutive cycles → out_valid from cycle 2, o_out=1..8 in order, in_ready stays 1, stall_cnt=0.
- Backpressure: accept A(o=0xA), then out_ready=0 and accept B(o=0xB) → next cycle in_ready=0, o_out=0xA. Offer C for 3 cycles → C not taken. out_ready=1 → outputs A, B, then C. stall_cnt=3.
- Flush with full skid: hold A in main and B in skid, assert flush with C offered → next cycle out_valid=0, ins_out=0, in_ready=1. A, B and C are never emitted.
- Reset mid-operation: hold A and B, pull reset low for 1 edge → out_valid=0, all outputs 0, stall_cnt=0, in_ready=1. The next accepted bundle D appears alone.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles → stall_cnt=15 and holds.
- Overflow passthrough: accept ovf_in=1 with ins=0xDEADBEEF → ovf_out=1, ins_out=0xDEADBEEF on the emit cycle.

Source files
------------

// File: rtl/pipe_skid_latch.sv
// Pipeline-stage latch with a valid/ready handshake, a 2-entry skid buffer, flush-to-NOP
// and a saturating stall counter. Generalises the former fixed 32-bit M/W latch.
module pipe_skid_latch #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned INS_W  = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] o_in,
    input  logic [DATA_W-1:0] d_in,
    input  logic [INS_W-1:0]  ins_in,
    input  logic              ovf_in,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] o_out,
    output logic [DATA_W-1:0] d_out,
    output logic [INS_W-1:0]  ins_out,
    output logic              ovf_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] o;
        logic [DATA_W-1:0] d;
        logic [INS_W-1:0]  ins;
        logic              ovf;
    } entry_t;

    entry_t           main_q;
    entry_t           skid_q;
    entry_t           in_entry;
    logic             in_ready_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             accept;
    logic             emit;

    assign accept   = in_valid & in_ready_q;
    assign emit     = main_q.valid & out_ready;
    assign in_entry = '{valid: 1'b1, o: o_in, d: d_in, ins: ins_in, ovf: ovf_in};

    // Entries are zeroed whenever they go invalid, so the outputs never show stale data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else if (skid_q.valid) begin
            // in_ready is low here, so only a drain of main can happen.
            if (emit) begin
                main_q     <= skid_q;
                skid_q     <= '0;
                in_ready_q <= 1'b1;
            end
        end else if (main_q.valid) begin
            if (accept && emit) begin
                main_q <= in_entry;
            end else if (accept) begin
                skid_q     <= in_entry;
                in_ready_q <= 1'b0;
            end else if (emit) begin
                main_q <= '0;
            end
        end else if (accept) begin
            main_q <= in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (main_q.valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_q.valid;
    assign o_out     = main_q.o;
    assign d_out     = main_q.d;
    assign ins_out   = main_q.ins;
    assign ovf_out   = main_q.ovf;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Directed bench for pipe_skid_latch: streaming, backpressure, flush, reset, counter
// saturation (on a second CNT_W=4 instance sharing the inputs) and overflow passthrough.
module tb_pipe_skid_latch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] o_in = '0;
    logic [31:0] d_in = '0;
    logic [31:0] ins_in = '0;
    logic        ovf_in = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] o_out;
    logic [31:0] d_out;
    logic [31:0] ins_out;
    logic        ovf_out;
    logic [15:0] stall_cnt;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] o_out4;
    logic [31:0] d_out4;
    logic [31:0] ins_out4;
    logic        ovf_out4;
    logic [3:0]  stall_cnt4;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pipe_skid_latch dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .o_in(o_in), .d_in(d_in), .ins_in(ins_in), .ovf_in(ovf_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .o_out(o_out), .d_out(d_out),
        .ins_out(ins_out), .ovf_out(ovf_out), .stall_cnt(stall_cnt)
    );

    pipe_skid_latch #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .o_in(o_in), .d_in(d_in), .ins_in(ins_in), .ovf_in(ovf_in), .flush(flush),
        .out_valid(out_valid4), .out_ready(out_ready), .o_out(o_out4), .d_out(d_out4),
        .ins_out(ins_out4), .ovf_out(ovf_out4), .stall_cnt(stall_cnt4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic offer(input logic [31:0] o);
        in_valid = 1'b1;
        o_in     = o;
        d_in     = o + 32'd100;
        ins_in   = o;
        ovf_in   = 1'b0;
    endtask

    initial begin
        // Reset state
        in_valid = 1'b1;
        out_ready = 1'b1;
        do_reset();
        in_valid = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_ins_out", ins_out, 0);
        check("rst_stall_cnt", stall_cnt, 0);

        // Streaming at one bundle per cycle
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            offer(i);
            step();
            check("stream_valid", out_valid, 1);
            check("stream_o", o_out, i);
            check("stream_d", d_out, i + 100);
            check("stream_ins", ins_out, i);
            check("stream_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", out_valid, 0);
        check("stream_o_zero", o_out, 0);
        check("stream_stall", stall_cnt, 0);

        // Backpressure: A in main, B in skid, C refused until skid drains
        do_reset();
        out_ready = 1'b0;
        offer(32'hA);
        step();
        check("bp_a_main", o_out, 32'hA);
        check("bp_ready_a", in_ready, 1);
        offer(32'hB);
        step();
        check("bp_ready_low", in_ready, 0);
        check("bp_hold_a", o_out, 32'hA);
        offer(32'hC);
        step();
        check("bp_hold_a2", o_out, 32'hA);
        check("bp_ready_low2", in_ready, 0);
        step();
        check("bp_hold_a3", o_out, 32'hA);
        out_ready = 1'b1;
        step();
        check("bp_emit_b", o_out, 32'hB);
        check("bp_ready_back", in_ready, 1);
        step();
        check("bp_emit_c", o_out, 32'hC);
        check("bp_c_ins", ins_out, 32'hC);
        in_valid = 1'b0;
        step();
        check("bp_empty", out_valid, 0);
        check("bp_stall", stall_cnt, 3);

        // Flush with a full skid and C offered
        do_reset();
        out_ready = 1'b0;
        offer(32'hA);
        step();
        offer(32'hB);
        step();
        check("fl_full", in_ready, 0);
        offer(32'hC);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ins", ins_out, 0);
        check("fl_o", o_out, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_stall_kept", stall_cnt, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_nothing_out", out_valid, 0);
        end

        // Reset mid-operation, then D appears alone
        out_ready = 1'b0;
        offer(32'hA);
        step();
        offer(32'hB);
        step();
        offer(32'hE);
        out_ready = 1'b1;
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("mr_valid", out_valid, 0);
        check("mr_o", o_out, 0);
        check("mr_d", d_out, 0);
        check("mr_ins", ins_out, 0);
        check("mr_ovf", ovf_out, 0);
        check("mr_stall", stall_cnt, 0);
        check("mr_in_ready", in_ready, 1);
        offer(32'hD);
        step();
        in_valid = 1'b0;
        check("mr_d_out", o_out, 32'hD);
        check("mr_d_valid", out_valid, 1);
        step();
        check("mr_d_alone", out_valid, 0);

        // Stall counter saturation on the 4-bit instance
        do_reset();
        out_ready = 1'b0;
        offer(32'h5);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("sat_cnt4", stall_cnt4, 15);
        check("sat_cnt16", stall_cnt, 20);
        step();
        check("sat_hold", stall_cnt4, 15);
        check("sat_valid4", out_valid4, 1);

        // Overflow flag and full instruction word pass through
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        o_in = 32'h1234;
        d_in = 32'h5678;
        ins_in = 32'hDEADBEEF;
        ovf_in = 1'b1;
        step();
        in_valid = 1'b0;
        ovf_in = 1'b0;
        check("ovf_valid", out_valid, 1);
        check("ovf_out", ovf_out, 1);
        check("ovf_ins", ins_out, 32'hDEADBEEF);
        step();
        check("ovf_cleared", ovf_out, 0);
        check("ovf_ins_nop", ins_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
